// File: rtl/ex_mem_skid_stage_if.sv
// EX->MEM stage bus: upstream valid/ready + payload, downstream valid/ready + head entry.
// Optional perf counter outputs present only when EX_MEM_PERF_EN is defined.
interface ex_mem_skid_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned WB_W   = 2,
    parameter int unsigned CNT_W  = 16
);
    // Elaboration-time sanity on widths
    if (DATA_W == 0 || RD_W == 0 || WB_W == 0 || CNT_W == 0) begin : g_bad_width
        $error("ex_mem_skid_stage_if: all widths must be non-zero");
    end

    // Upstream (EX) side
    logic              valid_i;
    logic              ready_o;
    logic              flush_i;
    logic [WB_W-1:0]   WB_i;
    logic [1:0]        MEM_i;
    logic [DATA_W-1:0] ALUOut_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [RD_W-1:0]   RDaddr_i;

    // Downstream (MEM) side
    logic              valid_o;
    logic              ready_i;
    logic [WB_W-1:0]   WB_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic [DATA_W-1:0] ALUOut_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [RD_W-1:0]   RDaddr_o;

`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport slave (
        input  valid_i, flush_i, WB_i, MEM_i, ALUOut_i, RTdata_i, RDaddr_i, ready_i,
        output ready_o, valid_o, WB_o, MemRead_o, MemWrite_o, ALUOut_o, RTdata_o, RDaddr_o,
        output stall_cnt_o, bubble_cnt_o, flush_cnt_o
    );

    modport master (
        output valid_i, flush_i, WB_i, MEM_i, ALUOut_i, RTdata_i, RDaddr_i, ready_i,
        input  ready_o, valid_o, WB_o, MemRead_o, MemWrite_o, ALUOut_o, RTdata_o, RDaddr_o,
        input  stall_cnt_o, bubble_cnt_o, flush_cnt_o
    );
`else
    modport slave (
        input  valid_i, flush_i, WB_i, MEM_i, ALUOut_i, RTdata_i, RDaddr_i, ready_i,
        output ready_o, valid_o, WB_o, MemRead_o, MemWrite_o, ALUOut_o, RTdata_o, RDaddr_o
    );

    modport master (
        output valid_i, flush_i, WB_i, MEM_i, ALUOut_i, RTdata_i, RDaddr_i, ready_i,
        input  ready_o, valid_o, WB_o, MemRead_o, MemWrite_o, ALUOut_o, RTdata_o, RDaddr_o
    );
`endif
endinterface

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with valid/ready flow control and a 2-entry skid buffer
// (main reg drives the outputs, skid reg absorbs one extra entry under back-pressure).
// ready_o is a function of state and reset only, so it never combinationally follows ready_i.
// Optional: define EX_MEM_PERF_EN for saturating stall/bubble/flush counters.
module ex_mem_skid_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned WB_W   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ex_mem_skid_stage_if.slave  bus
);

    // Elaboration-time sanity on widths
    if (DATA_W == 0 || RD_W == 0 || WB_W == 0 || CNT_W == 0) begin : g_bad_width
        $error("ex_mem_skid_stage: all widths must be non-zero");
    end

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [1:0]        mem;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rt;
        logic [RD_W-1:0]   rd;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t main_q,  main_d;
    entry_t skid_q,  skid_d;

    logic   ready_c;
    logic   valid_c;
    logic   accept_c;
    logic   emit_c;
    entry_t in_c;

    // Handshake terms
    assign ready_c  = rst_i & (state_q != ST_FULL);
    assign valid_c  = (state_q != ST_EMPTY);
    assign accept_c = bus.valid_i & ready_c;
    assign emit_c   = valid_c & bus.ready_i;

    // Incoming entry
    assign in_c = '{wb: bus.WB_i, mem: bus.MEM_i, alu: bus.ALUOut_i,
                    rt: bus.RTdata_i, rd: bus.RDaddr_i};

    // Next-state and storage update; flush overrides everything and leaves data untouched
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    main_d  = in_c;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && emit_c) begin
                    main_d = in_c;
                end else if (accept_c) begin
                    skid_d  = in_c;
                    state_d = ST_FULL;
                end else if (emit_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit_c) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (bus.flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // State and storage registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Head outputs; control is gated so an empty stage presents a NOP
    assign bus.ready_o    = ready_c;
    assign bus.valid_o    = valid_c;
    assign bus.WB_o       = main_q.wb & {WB_W{valid_c}};
    assign bus.MemRead_o  = main_q.mem[0] & valid_c;
    assign bus.MemWrite_o = main_q.mem[1] & valid_c;
    assign bus.ALUOut_o   = main_q.alu;
    assign bus.RTdata_o   = main_q.rt;
    assign bus.RDaddr_o   = main_q.rd;

`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (valid_c && !bus.ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!valid_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (bus.flush_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset only
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: directed vector table, a hand-written stall sequence,
// then randomized traffic against a queue-based reference model.
module tb_ex_mem_skid_stage;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    ex_mem_skid_stage_if #(.DATA_W(32), .RD_W(5), .WB_W(2), .CNT_W(CNT_W)) bus ();

    ex_mem_skid_stage #(.DATA_W(32), .RD_W(5), .WB_W(2), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  rd;
    } ent_t;

    typedef struct {
        logic        rst, v, r, f;
        logic [1:0]  mem, wb;
        logic [31:0] alu;
        logic        e_v, e_r;
        logic [31:0] e_alu;
        logic [1:0]  e_mem, e_wb;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: ordered queue of held entries plus the last head shown
    ent_t q[$];
    ent_t last_head;
    int unsigned stall_m, bubble_m, flush_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, v, r, f, input logic [1:0] mem, wb,
                                input logic [31:0] alu, input logic e_v, e_r,
                                input logic [31:0] e_alu, input logic [1:0] e_mem, e_wb);
        vec_t t;
        t.rst = rst; t.v = v; t.r = r; t.f = f; t.mem = mem; t.wb = wb; t.alu = alu;
        t.e_v = e_v; t.e_r = e_r; t.e_alu = e_alu; t.e_mem = e_mem; t.e_wb = e_wb;
        return t;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at the next negedge
    task automatic cycle(input logic rst, v, r, f, input ent_t e);
        bit acc, em;
        rst_i        = rst;
        bus.valid_i  = v;
        bus.ready_i  = r;
        bus.flush_i  = f;
        bus.WB_i     = e.wb;
        bus.MEM_i    = e.mem;
        bus.ALUOut_i = e.alu;
        bus.RTdata_i = e.rt;
        bus.RDaddr_i = e.rd;
        @(posedge clk_i);
        if (!rst) begin
            q.delete();
            last_head = '0;
            stall_m = 0; bubble_m = 0; flush_m = 0;
        end else begin
            acc = v && (q.size() < 2);
            em  = (q.size() > 0) && r;
            if (q.size() > 0 && !r && stall_m < CNT_MAX) stall_m++;
            if (q.size() == 0 && bubble_m < CNT_MAX) bubble_m++;
            if (f && flush_m < CNT_MAX) flush_m++;
            if (f) begin
                q.delete();
            end else begin
                if (em) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            if (q.size() > 0) last_head = q[0];
        end
        @(negedge clk_i);
        cyc++;
    endtask

    // Compare every DUT output against the model
    task automatic check_model();
        bit ev;
        ev = (q.size() > 0);
        chk("valid_o",    32'(bus.valid_o),    32'(ev));
        chk("ready_o",    32'(bus.ready_o),    32'(rst_i && q.size() < 2));
        chk("WB_o",       32'(bus.WB_o),       32'(ev ? last_head.wb : 2'b00));
        chk("MemRead_o",  32'(bus.MemRead_o),  32'(ev & last_head.mem[0]));
        chk("MemWrite_o", 32'(bus.MemWrite_o), 32'(ev & last_head.mem[1]));
        chk("ALUOut_o",   bus.ALUOut_o,        last_head.alu);
        chk("RTdata_o",   bus.RTdata_o,        last_head.rt);
        chk("RDaddr_o",   32'(bus.RDaddr_o),   32'(last_head.rd));
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt_o",  32'(bus.stall_cnt_o),  stall_m);
        chk("bubble_cnt_o", 32'(bus.bubble_cnt_o), bubble_m);
        chk("flush_cnt_o",  32'(bus.flush_cnt_o),  flush_m);
`endif
    endtask

    vec_t vecs[24];

    initial begin
        ent_t e;
        last_head = '0;
        stall_m = 0; bubble_m = 0; flush_m = 0;

        // rst, v, r, f, mem, wb, alu  ->  valid_o, ready_o, ALUOut_o, {MemWrite,MemRead}, WB_o
        vecs[0]  = mk(0,0,0,0, 2'b00,2'b00, 32'h0,   0,0, 32'h0,   2'b00,2'b00);
        vecs[1]  = mk(0,0,0,0, 2'b00,2'b00, 32'h0,   0,0, 32'h0,   2'b00,2'b00);
        vecs[2]  = mk(1,0,1,0, 2'b00,2'b00, 32'h0,   0,1, 32'h0,   2'b00,2'b00);
        vecs[3]  = mk(1,1,1,0, 2'b01,2'b01, 32'h1,   1,1, 32'h1,   2'b01,2'b01);
        vecs[4]  = mk(1,1,1,0, 2'b01,2'b01, 32'h2,   1,1, 32'h2,   2'b01,2'b01);
        vecs[5]  = mk(1,1,1,0, 2'b01,2'b01, 32'h3,   1,1, 32'h3,   2'b01,2'b01);
        vecs[6]  = mk(1,1,1,0, 2'b01,2'b01, 32'h4,   1,1, 32'h4,   2'b01,2'b01);
        vecs[7]  = mk(1,0,1,0, 2'b00,2'b00, 32'h0,   0,1, 32'h4,   2'b00,2'b00);
        vecs[8]  = mk(1,1,0,0, 2'b10,2'b11, 32'h10,  1,1, 32'h10,  2'b10,2'b11);
        vecs[9]  = mk(1,1,0,0, 2'b10,2'b10, 32'h20,  1,0, 32'h10,  2'b10,2'b11);
        vecs[10] = mk(1,1,0,0, 2'b01,2'b01, 32'h30,  1,0, 32'h10,  2'b10,2'b11);
        vecs[11] = mk(1,0,1,0, 2'b00,2'b00, 32'h0,   1,1, 32'h20,  2'b10,2'b10);
        vecs[12] = mk(1,0,1,0, 2'b00,2'b00, 32'h0,   0,1, 32'h20,  2'b00,2'b00);
        vecs[13] = mk(1,1,0,0, 2'b10,2'b01, 32'h40,  1,1, 32'h40,  2'b10,2'b01);
        vecs[14] = mk(1,1,0,0, 2'b10,2'b01, 32'h50,  1,0, 32'h40,  2'b10,2'b01);
        vecs[15] = mk(1,1,0,1, 2'b10,2'b01, 32'h60,  0,1, 32'h40,  2'b00,2'b00);
        vecs[16] = mk(1,0,1,0, 2'b00,2'b00, 32'h0,   0,1, 32'h40,  2'b00,2'b00);
        vecs[17] = mk(1,1,0,0, 2'b01,2'b10, 32'h70,  1,1, 32'h70,  2'b01,2'b10);
        vecs[18] = mk(1,1,1,1, 2'b10,2'b11, 32'h80,  0,1, 32'h70,  2'b00,2'b00);
        vecs[19] = mk(1,0,1,0, 2'b00,2'b00, 32'h0,   0,1, 32'h70,  2'b00,2'b00);
        vecs[20] = mk(1,1,0,0, 2'b10,2'b01, 32'h90,  1,1, 32'h90,  2'b10,2'b01);
        vecs[21] = mk(1,1,0,0, 2'b01,2'b10, 32'hA0,  1,0, 32'h90,  2'b10,2'b01);
        vecs[22] = mk(0,1,1,0, 2'b00,2'b00, 32'h0,   0,0, 32'h0,   2'b00,2'b00);
        vecs[23] = mk(1,0,1,0, 2'b00,2'b00, 32'h0,   0,1, 32'h0,   2'b00,2'b00);

        @(negedge clk_i);

        // Directed table
        for (int i = 0; i < 24; i++) begin
            e = '{wb: vecs[i].wb, mem: vecs[i].mem, alu: vecs[i].alu,
                  rt: 32'h0, rd: 5'h0};
            cycle(vecs[i].rst, vecs[i].v, vecs[i].r, vecs[i].f, e);
            chk("tbl_valid_o",    32'(bus.valid_o),    32'(vecs[i].e_v));
            chk("tbl_ready_o",    32'(bus.ready_o),    32'(vecs[i].e_r));
            chk("tbl_ALUOut_o",   bus.ALUOut_o,        vecs[i].e_alu);
            chk("tbl_MemRead_o",  32'(bus.MemRead_o),  32'(vecs[i].e_mem[0]));
            chk("tbl_MemWrite_o", 32'(bus.MemWrite_o), 32'(vecs[i].e_mem[1]));
            chk("tbl_WB_o",       32'(bus.WB_o),       32'(vecs[i].e_wb));
        end

        // Hand sequence: fill both slots, then hold five stall cycles, then drain in order
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_model();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '{wb: 2'b11, mem: 2'b10, alu: 32'hAAAA0001, rt: 32'h1111, rd: 5'd3});
        check_model();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '{wb: 2'b01, mem: 2'b01, alu: 32'hAAAA0002, rt: 32'h2222, rd: 5'd7});
        check_model();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, '{wb: 2'b10, mem: 2'b11, alu: 32'hDEAD0000, rt: 32'h0, rd: 5'd31});
            check_model();
            chk("stall_head", bus.ALUOut_o, 32'hAAAA0001);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check_model();
        chk("drain_second", bus.ALUOut_o, 32'hAAAA0002);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check_model();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            e.wb  = 2'($urandom);
            e.mem = 2'($urandom);
            e.alu = $urandom;
            e.rt  = $urandom;
            e.rd  = 5'($urandom);
            cycle(($urandom_range(0, 99) >= 2),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 99) < 5),
                  e);
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
